tc_history_tap: RTL and testbench
=================================

Name: tc_history_tap

Overview:
- Tapped history buffer: records one `size`-bit sample per shift into a circular store of `depth` entries.
- Returns, registered, the sample selected by a runtime tap index.
- It is the read-side counterpart to the fixed two-stage delay line. With `shift` held high and `tap`=0, `out` equals `in` delayed by exactly 2 clocks, the same timing as that delay line. Larger taps add one clock each.
- Used wherever game circuits need a selectable look-back instead of a fixed delay.

Parameters:
- size, 1, data width of `in`/`out` in bits.
- depth, 8, number of history entries; legal range 2..256, need not be a power of two.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- shift  input  1  1 = capture `in` into history this cycle.
- in  input  size  sample to record.
- tap  input  TW  look-back index, TW = max(1, clog2(depth)); 0 = newest stored sample.
- out  output  size  registered selected sample.
- valid  output  1  registered; 1 when `out` holds a real stored sample.

Behaviour:
- State: write pointer wp (TW bits, 0..depth-1), fill count (0..depth), storage array, out register, valid register.
- Reset (rst=1 at posedge): wp<=0, fill<=0, out<=0, valid<=0. The storage array is not cleared; fill=0 masks it. Reset has priority over shift and read on that same edge.
- Write, on posedge with shift=1 and rst=0:
  - mem[wp]<=in.
  - wp<=wp+1, wrapping from depth-1 to 0.
  - fill<=fill+1, saturating at depth.
- shift=0: wp, fill and mem hold.
- Read, every posedge with rst=0, using pre-edge state:
  - if tap<fill: out<=mem[(wp-1-tap) mod depth], valid<=1.
  - else: out<=0, valid<=0.
- The modular index is computed without relying on power-of-two wrap: idx = wp-1-tap, plus depth if negative.
- Simultaneous shift and read: the read sees the old wp/fill. The sample written on edge k is readable at tap=0 on edge k+1. Total in-to-out latency is 2 clocks at tap=0 and tap+2 clocks in general, with continuous shift.
- Out-of-range: tap>=depth (possible when depth is not a power of two) gives out=0, valid=0, never an X or aliased read.
- Wrap-around: after more than depth shifts, the oldest entry is overwritten. tap=depth-1 then returns the sample written depth shifts ago.
- Reset mid-operation: all history is logically discarded. The first post-reset shift starts at wp=0, and valid stays 0 until that sample exists.
- Outputs are always driven (no tri-state) and equal 0 whenever valid=0.

Optional Feature:
- Macro: TC_HISTORY_TAP_OCCUPANCY_EN.
- Defined: adds output port `count`, width clog2(depth+1). It equals the current fill register, 0 after reset, and saturates at depth.
- Undefined: the port is absent and the fill register is used only internally. All other behaviour is identical.

Decomposition:
- Shared package tc_history_pkg holds:
  - a constant function for index width (max(1, clog2(n))).
  - a modular-decrement helper function (ptr, offset, depth).
- Natural sub-module tc_history_ram:
  - `depth`x`size` array.
  - one synchronous write port (we, waddr, wdata).
  - one combinational read port (raddr, rdata).
  - No reset.
- Top level holds pointer, fill, tap-range check and the output register.

Test Plan:
- size=8, depth=8, shift=1 continuous, tap=0, in=1,2,3,... from cycle 0 after reset → out=0, valid=0 for cycles 0-1; then out=1,2,3,... (exact 2-clock delay).
- Same stream, tap=3 → valid rises on the edge after the 4th shift; out tracks in delayed by 5 clocks (first value 1).
- Fill 5 samples 10..14, then shift=0; sweep tap 0..7 → out=14,13,12,11,10, then 0,0,0 with valid=0 for taps 5-7.
- depth=5, 12 shifts of 0..11, tap=4 → out=7; tap=0 → out=11; tap=7 (out of range) → out=0, valid=0.
- Mid-stream rst pulse for 1 cycle while shift=1 → next edge out=0, valid=0; the following edge with tap=0 shows the first post-reset sample; with the macro, count=1 after it.
- Shift toggled every other cycle, tap=0 → out repeats each stored sample for 2 cycles; no sample is skipped or duplicated in history.

Source files
------------

// File: rtl/tc_history_pkg.sv
// Shared helpers for the tapped history buffer: index width and modular
// pointer decrement that works for any depth, power of two or not.
package tc_history_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 256;

  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // ptr - offset folded back into 0..depth-1; offset must not exceed ptr + depth.
  function automatic int mod_dec(input int ptr, input int offset, input int depth);
    int d;
    d = ptr - offset;
    if (d < 0) d = d + depth;
    return d;
  endfunction

endpackage

// File: rtl/tc_history_ram.sv
// History storage: depth x size array, one synchronous write port and one
// combinational read port, no reset.
module tc_history_ram #(
  parameter int size  = 1,
  parameter int depth = 8,
  parameter int aw    = 3
) (
  input  logic            clk,
  input  logic            we,
  input  logic [aw-1:0]   waddr,
  input  logic [size-1:0] wdata,
  input  logic [aw-1:0]   raddr,
  output logic [size-1:0] rdata
);

  logic [size-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tc_history_tap.sv
// Tapped history buffer with registered, runtime-selectable look-back.
// Optional occupancy output enabled by TC_HISTORY_TAP_OCCUPANCY_EN.
module tc_history_tap
  import tc_history_pkg::*;
#(
  parameter  int size  = 1,
  parameter  int depth = 8,
  localparam int TW    = idx_width(depth),
  localparam int FW    = $clog2(depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            shift,
  input  logic [size-1:0] in,
  input  logic [TW-1:0]   tap,
  output logic [size-1:0] out,
  output logic            valid
`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
  ,
  output logic [FW-1:0]   count
`endif
);

  logic [TW-1:0]   wp;
  logic [FW-1:0]   fill;
  logic [TW-1:0]   raddr;
  logic [size-1:0] rdata;
  logic            in_range;

  // Taps at or beyond the fill level are masked and read a safe address,
  // which also covers tap >= depth when depth is not a power of two.
  always_comb begin
    in_range = (32'(tap) < 32'(fill));
    raddr    = '0;
    if (in_range) raddr = TW'(mod_dec(int'(wp), int'(tap) + 1, depth));
  end

  tc_history_ram #(
    .size  (size),
    .depth (depth),
    .aw    (TW)
  ) u_ram (
    .clk   (clk),
    .we    (shift & ~rst),
    .waddr (wp),
    .wdata (in),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      fill  <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else begin
      if (shift) begin
        wp <= (wp == TW'(depth - 1)) ? '0 : wp + 1'b1;
        if (fill != FW'(depth)) fill <= fill + 1'b1;
      end
      if (in_range) begin
        out   <= rdata;
        valid <= 1'b1;
      end else begin
        out   <= '0;
        valid <= 1'b0;
      end
    end
  end

`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
  assign count = fill;
`endif

endmodule

// File: tb/tb_tc_history_tap.sv
// Directed bench for tc_history_tap: depth 8 and depth 5 instances, size 8.
module tb_tc_history_tap;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift;
  logic [7:0] in;
  logic [2:0] tap_a, tap_b;
  logic [7:0] out_a, out_b;
  logic       valid_a, valid_b;
`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
  logic [3:0] count_a;
  logic [2:0] count_b;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  tc_history_tap #(.size(8), .depth(8)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .in    (in),
    .tap   (tap_a),
    .out   (out_a),
    .valid (valid_a)
`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
    ,
    .count (count_a)
`endif
  );

  tc_history_tap #(.size(8), .depth(5)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .in    (in),
    .tap   (tap_b),
    .out   (out_b),
    .valid (valid_b)
`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
    ,
    .count (count_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; shift = 1'b0; in = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; shift = 1'b1; in = 8'hAA; tap_a = 3'd0; tap_b = 3'd0;
    step();
    checks++;
    if (out_a !== 8'd0 || valid_a !== 1'b0)
      $display("FAIL reset_a: out=%0d valid=%0b required out=0 valid=0", out_a, valid_a);
    else passed++;
`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
    checks++;
    if (count_a !== 4'd0) $display("FAIL reset_count: count=%0d required 0", count_a);
    else passed++;
`endif
    rst = 1'b0; shift = 1'b0;
  endtask

  task automatic test_tap0_stream();
    logic [7:0] exp_out;
    logic       exp_v;
    do_reset();
    tap_a = 3'd0; shift = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in = 8'(k + 1);
      step();
      exp_v   = (k >= 1);
      exp_out = exp_v ? 8'(k) : 8'd0;
      checks++;
      if (out_a !== exp_out || valid_a !== exp_v)
        $display("FAIL tap0_stream k=%0d: out=%0d valid=%0b required out=%0d valid=%0b",
                 k, out_a, valid_a, exp_out, exp_v);
      else passed++;
    end
    shift = 1'b0;
  endtask

  task automatic test_tap3_stream();
    logic [7:0] exp_out;
    logic       exp_v;
    do_reset();
    tap_a = 3'd3; shift = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in = 8'(k + 1);
      step();
      exp_v   = (k >= 4);
      exp_out = exp_v ? 8'(k - 3) : 8'd0;
      checks++;
      if (out_a !== exp_out || valid_a !== exp_v)
        $display("FAIL tap3_stream k=%0d: out=%0d valid=%0b required out=%0d valid=%0b",
                 k, out_a, valid_a, exp_out, exp_v);
      else passed++;
    end
    shift = 1'b0;
  endtask

  task automatic test_tap_sweep();
    logic [7:0] exp_out [8] = '{8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd0, 8'd0, 8'd0};
    do_reset();
    shift = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in = 8'(10 + k);
      step();
    end
    shift = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tap_a = 3'(t);
      step();
      checks++;
      if (out_a !== exp_out[t] || valid_a !== (t < 5))
        $display("FAIL tap_sweep tap=%0d: out=%0d valid=%0b required out=%0d valid=%0b",
                 t, out_a, valid_a, exp_out[t], (t < 5));
      else passed++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    shift = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in = 8'(100 + k);
      step();
    end
    shift = 1'b0;
    tap_a = 3'd7;
    step();
    checks++;
    if (out_a !== 8'd102 || valid_a !== 1'b1)
      $display("FAIL wrap_tap7: out=%0d valid=%0b required out=102 valid=1", out_a, valid_a);
    else passed++;
    tap_a = 3'd0;
    step();
    checks++;
    if (out_a !== 8'd109 || valid_a !== 1'b1)
      $display("FAIL wrap_tap0: out=%0d valid=%0b required out=109 valid=1", out_a, valid_a);
    else passed++;
`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
    checks++;
    if (count_a !== 4'd8) $display("FAIL wrap_count: count=%0d required 8", count_a);
    else passed++;
`endif
  endtask

  task automatic test_depth5();
    do_reset();
    shift = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in = 8'(k);
      step();
    end
    shift = 1'b0;
    tap_b = 3'd4;
    step();
    checks++;
    if (out_b !== 8'd7 || valid_b !== 1'b1)
      $display("FAIL d5_tap4: out=%0d valid=%0b required out=7 valid=1", out_b, valid_b);
    else passed++;
    tap_b = 3'd0;
    step();
    checks++;
    if (out_b !== 8'd11 || valid_b !== 1'b1)
      $display("FAIL d5_tap0: out=%0d valid=%0b required out=11 valid=1", out_b, valid_b);
    else passed++;
    tap_b = 3'd7;
    step();
    checks++;
    if (out_b !== 8'd0 || valid_b !== 1'b0)
      $display("FAIL d5_tap7: out=%0d valid=%0b required out=0 valid=0", out_b, valid_b);
    else passed++;
    tap_b = 3'd5;
    step();
    checks++;
    if (out_b !== 8'd0 || valid_b !== 1'b0)
      $display("FAIL d5_tap5: out=%0d valid=%0b required out=0 valid=0", out_b, valid_b);
    else passed++;
`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
    checks++;
    if (count_b !== 3'd5) $display("FAIL d5_count: count=%0d required 5", count_b);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    tap_a = 3'd0; shift = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in = 8'(30 + k);
      step();
    end
    rst = 1'b1; in = 8'd50;
    step();
    checks++;
    if (out_a !== 8'd0 || valid_a !== 1'b0)
      $display("FAIL rst_mid_edge: out=%0d valid=%0b required out=0 valid=0", out_a, valid_a);
    else passed++;
    rst = 1'b0; in = 8'd60;
    step();
    checks++;
    if (out_a !== 8'd0 || valid_a !== 1'b0)
      $display("FAIL rst_mid_first: out=%0d valid=%0b required out=0 valid=0", out_a, valid_a);
    else passed++;
`ifdef TC_HISTORY_TAP_OCCUPANCY_EN
    checks++;
    if (count_a !== 4'd1) $display("FAIL rst_mid_count: count=%0d required 1", count_a);
    else passed++;
`endif
    shift = 1'b0;
    step();
    checks++;
    if (out_a !== 8'd60 || valid_a !== 1'b1)
      $display("FAIL rst_mid_sample: out=%0d valid=%0b required out=60 valid=1", out_a, valid_a);
    else passed++;
    tap_a = 3'd1;
    step();
    checks++;
    if (out_a !== 8'd0 || valid_a !== 1'b0)
      $display("FAIL rst_mid_old: out=%0d valid=%0b required out=0 valid=0", out_a, valid_a);
    else passed++;
  endtask

  task automatic test_toggle_shift();
    logic [7:0] exp_out;
    logic [7:0] hist [3] = '{8'd202, 8'd201, 8'd200};
    do_reset();
    tap_a = 3'd0;
    for (int k = 0; k < 6; k++) begin
      shift = (k % 2 == 0);
      in    = shift ? 8'(200 + k / 2) : 8'hFF;
      step();
      exp_out = (k >= 1) ? 8'(200 + (k - 1) / 2) : 8'd0;
      checks++;
      if (out_a !== exp_out || valid_a !== (k >= 1))
        $display("FAIL toggle k=%0d: out=%0d valid=%0b required out=%0d valid=%0b",
                 k, out_a, valid_a, exp_out, (k >= 1));
      else passed++;
    end
    shift = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tap_a = 3'(t);
      step();
      exp_out = (t < 3) ? hist[t] : 8'd0;
      checks++;
      if (out_a !== exp_out || valid_a !== (t < 3))
        $display("FAIL toggle_hist tap=%0d: out=%0d valid=%0b required out=%0d valid=%0b",
                 t, out_a, valid_a, exp_out, (t < 3));
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; shift = 1'b0; in = '0; tap_a = '0; tap_b = '0;
    test_reset();
    test_tap0_stream();
    test_tap3_stream();
    test_tap_sweep();
    test_wrap();
    test_depth5();
    test_reset_mid();
    test_toggle_shift();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
